// File: rtl/ov2640_sccb_config.sv
// OV2640 power-up sequencer: walks a {reg,val} ROM table and issues SCCB 3-phase
// writes, then raises cam_enable. The 16'hFFF0 entry inserts a delay and 16'hFFFF ends the table.
module ov2640_sccb_config #(
  parameter int          CLK_FREQ_HZ  = 50000000,
  parameter int          SCCB_FREQ_HZ = 100000,
  parameter logic [7:0]  DEV_ADDR     = 8'h60,
  parameter int          ADDR_W       = 8,
  parameter int          PWR_WAIT     = 1000000,
  parameter int          DELAY_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cam_enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sio_c,
  output logic              sio_d_o,
  output logic              sio_d_oe
);

  localparam int QTR  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW   = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int WMAX = (PWR_WAIT > DELAY_CYCLES) ? PWR_WAIT : DELAY_CYCLES;
  localparam int CW   = $clog2(WMAX + 1);

  localparam logic [QW-1:0]     Q_LAST    = QW'(QTR - 1);
  localparam logic [CW-1:0]     PWR_LAST  = CW'(PWR_WAIT - 1);
  localparam logic [CW-1:0]     DLY_LAST  = CW'(DELAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_DECODE, S_START,
    S_SHIFT, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t            state_q, state_n;
  logic [QW-1:0]     q_cnt;
  logic [1:0]        q_ph;
  logic [4:0]        bit_cnt;
  logic [CW-1:0]     wcnt;
  logic [26:0]       sh;
  logic              qtick, advance, c_n, oe_n, q_timed, w_timed, idle_like;

  assign qtick      = (q_cnt == Q_LAST);
  assign q_timed    = (state_q == S_START) || (state_q == S_SHIFT) ||
                      (state_q == S_STOP)  || (state_q == S_GAP);
  assign w_timed    = (state_q == S_PWR) || (state_q == S_DELAY);
  assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy       = !idle_like;
  assign done       = (state_q == S_DONE);
  assign cam_enable = done;
  assign sio_d_o    = 1'b0;

  // Outputs are registered, so SIO_D decisions look at the current (registered)
  // SIO_C: data is only allowed to move once SIO_C is already seen low.
  always_comb begin
    state_n = state_q;
    c_n     = 1'b1;
    oe_n    = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_n = S_PWR;
      S_PWR:    if (wcnt == PWR_LAST) state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF)      state_n = S_DONE;
        else if (rom_data == 16'hFFF0) state_n = S_DELAY;
        else                           state_n = S_START;
      end
      S_START: begin
        oe_n = q_ph[0];
        if (qtick && q_ph == 2'd1) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        c_n  = q_ph[1];
        oe_n = sio_c ? sio_d_oe : ~sh[26];
        if (qtick && q_ph == 2'd3 && bit_cnt == 5'd0) state_n = S_STOP;
      end
      S_STOP: begin
        c_n = (q_ph != 2'd0);
        case (q_ph)
          2'd0:    oe_n = sio_c ? sio_d_oe : 1'b1;
          2'd1:    oe_n = 1'b1;
          default: oe_n = 1'b0;
        endcase
        if (qtick && q_ph == 2'd2) state_n = S_GAP;
      end
      S_GAP:   if (qtick && q_ph == 2'd3) advance = 1'b1;
      S_DELAY: if (wcnt == DLY_LAST) advance = 1'b1;
      default: state_n = S_IDLE;
    endcase
    if (advance) state_n = (rom_addr == ADDR_LAST) ? S_DONE : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      q_cnt    <= '0;
      q_ph     <= '0;
      bit_cnt  <= '0;
      wcnt     <= '0;
      sh       <= '0;
      rom_addr <= '0;
      sio_c    <= 1'b1;
      sio_d_oe <= 1'b0;
    end else begin
      state_q  <= state_n;
      sio_c    <= c_n;
      sio_d_oe <= oe_n;
      if (state_n != state_q) begin
        q_cnt <= '0;
        q_ph  <= '0;
        wcnt  <= '0;
      end else begin
        if (q_timed) begin
          if (qtick) begin
            q_cnt <= '0;
            q_ph  <= q_ph + 2'd1;
          end else begin
            q_cnt <= q_cnt + QW'(1);
          end
        end
        if (w_timed) wcnt <= wcnt + CW'(1);
      end
      // Frame bits: ID, X, reg, X, val, X -- X bits are 1 so SIO_D is released.
      if (state_q == S_DECODE && state_n == S_START) begin
        sh      <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
        bit_cnt <= 5'd26;
      end else if (state_q == S_SHIFT && qtick && q_ph == 2'd3) begin
        sh      <= {sh[25:0], 1'b0};
        bit_cnt <= bit_cnt - 5'd1;
      end
      if (idle_like && start)                     rom_addr <= '0;
      else if (advance && rom_addr != ADDR_LAST)  rom_addr <= rom_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_ov2640_sccb_config.sv
// Directed bench for ov2640_sccb_config: a SCCB bus monitor decodes frames on two
// instances (8-bit and 2-bit ROM address) and compares against hand-built tables.
module tb_ov2640_sccb_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic        busy, done, cam_enable, sio_c, sio_d_o, sio_d_oe;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy2, done2, cam_enable2, sio_c2, sio_d_o2, sio_d_oe2;
  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2;

  logic [15:0] rom  [256];
  logic [15:0] rom2 [4];

  ov2640_sccb_config #(.CLK_FREQ_HZ(4000000), .SCCB_FREQ_HZ(100000), .DEV_ADDR(8'h60),
    .ADDR_W(8), .PWR_WAIT(20), .DELAY_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .cam_enable(cam_enable),
    .rom_addr(rom_addr), .rom_data(rom_data), .sio_c(sio_c), .sio_d_o(sio_d_o), .sio_d_oe(sio_d_oe));

  ov2640_sccb_config #(.CLK_FREQ_HZ(4000000), .SCCB_FREQ_HZ(100000), .DEV_ADDR(8'h60),
    .ADDR_W(2), .PWR_WAIT(20), .DELAY_CYCLES(100)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .cam_enable(cam_enable2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .sio_c(sio_c2), .sio_d_o(sio_d_o2), .sio_d_oe(sio_d_oe2));

  int cyc = 0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom2[rom_addr2];
  end

  // SCCB monitor for both instances, sampled on the falling clock edge
  logic [1:0]  scl, sda;
  assign scl = {sio_c2, sio_c};
  assign sda = {~sio_d_oe2, ~sio_d_oe};
  logic [1:0]  pscl = 2'b11, psda = 2'b11;
  int          n_start[2], n_stop[2], n_viol[2], n_bad[2], nfr[2], nbits[2], start_cyc[2];
  logic [26:0] sr[2];
  logic [26:0] fr[2][64];

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_start[k] = 0; n_stop[k] = 0; n_viol[k] = 0; n_bad[k] = 0;
      nfr[k] = 0; nbits[k] = 0; start_cyc[k] = 0; sr[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (scl[k] && pscl[k] && sda[k] != psda[k]) begin
          if (!sda[k]) begin
            n_start[k]++; nbits[k] = 0; start_cyc[k] = cyc;
          end else begin
            n_stop[k]++;
            if (nbits[k] == 27 && nfr[k] < 64) begin fr[k][nfr[k]] = sr[k]; nfr[k]++; end
            else n_bad[k]++;
          end
        end else if (sda[k] != psda[k] && scl[k] != pscl[k]) begin
          n_viol[k]++;
        end
        if (scl[k] && !pscl[k] && nbits[k] < 27) begin
          sr[k] = {sr[k][25:0], sda[k]}; nbits[k]++;
        end
        pscl[k] = scl[k]; psda[k] = sda[k];
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic chk_frame(input int k, input int idx, input logic [7:0] r, input logic [7:0] v);
    logic [26:0] f;
    f = fr[k][idx];
    chk($sformatf("frame%0d_%0d_id", k, idx),  {24'd0, f[26:19]}, 32'h60);
    chk($sformatf("frame%0d_%0d_x", k, idx),   {29'd0, f[18], f[9], f[0]}, 32'h7);
    chk($sformatf("frame%0d_%0d_reg", k, idx), {24'd0, f[17:10]}, {24'd0, r});
    chk($sformatf("frame%0d_%0d_val", k, idx), {24'd0, f[8:1]}, {24'd0, v});
  endtask

  // Pulse start on instance k, optionally re-pulse it mid-run, and wait for done.
  task automatic run(input int k, input int restart_at, output int lat);
    int t0;
    @(negedge clk);
    if (k == 0) start = 1'b1; else start2 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    chk($sformatf("done_drop%0d", k), (k == 0) ? {cam_enable, done} : {cam_enable2, done2}, 0);
    chk($sformatf("busy_set%0d", k), (k == 0) ? busy : busy2, 1);
    lat = -1;
    for (int i = 0; i < 20000; i++) begin
      start = 1'b0; start2 = 1'b0;
      if ((k == 0) ? done : done2) begin lat = cyc - t0; break; end
      if (i == restart_at) begin if (k == 0) start = 1'b1; else start2 = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0; start2 = 1'b0;
    checks++;
    if (lat < 0) begin errors++; $display("FAIL timeout%0d: got no done want done", k); end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [7:0]  r;
    logic [7:0]  v;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } rstv_t;

  vec_t  tbl[4];
  vec_t  tbl2[4];
  rstv_t rv[7];
  int    lat, b_start, b_stop, b_viol, b_bad, b_fr;

  initial begin
    tbl[0]  = '{16'h1280, 8'h12, 8'h80};
    tbl[1]  = '{16'h3A04, 8'h3A, 8'h04};
    tbl[2]  = '{16'hFF01, 8'hFF, 8'h01};
    tbl[3]  = '{16'h00FF, 8'h00, 8'hFF};
    tbl2[0] = '{16'h1122, 8'h11, 8'h22};
    tbl2[1] = '{16'h3344, 8'h33, 8'h44};
    tbl2[2] = '{16'hA55A, 8'hA5, 8'h5A};
    tbl2[3] = '{16'h7F80, 8'h7F, 8'h80};
    rv[0] = '{"rst_sio_c", 32'd1}; rv[1] = '{"rst_oe", 32'd0};   rv[2] = '{"rst_do", 32'd0};
    rv[3] = '{"rst_busy", 32'd0};  rv[4] = '{"rst_done", 32'd0}; rv[5] = '{"rst_cam", 32'd0};
    rv[6] = '{"rst_addr", 32'd0};
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++) rom2[i] = tbl2[i].word;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      logic [31:0] act;
      case (i)
        0: act = {31'd0, sio_c};
        1: act = {31'd0, sio_d_oe};
        2: act = {31'd0, sio_d_o};
        3: act = {31'd0, busy};
        4: act = {31'd0, done};
        5: act = {31'd0, cam_enable};
        default: act = {24'd0, rom_addr};
      endcase
      chk(rv[i].nm, act, rv[i].exp);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write, with an ignored start pulse in the middle of it
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    b_start = n_start[0]; b_stop = n_stop[0]; b_fr = nfr[0]; b_viol = n_viol[0];
    run(0, 500, lat);
    chk_rng("single_latency", lat, 1194, 1198);
    chk("single_frames", nfr[0] - b_fr, 1);
    chk_frame(0, b_fr, 8'h12, 8'h80);
    chk("single_cam", cam_enable, 1);
    chk("single_busy", busy, 0);
    chk("single_addr", {24'd0, rom_addr}, 32'd1);
    chk("single_viol", n_viol[0] - b_viol, 0);

    // Delay entry ahead of one write
    rom[0] = 16'hFFF0; rom[1] = 16'hFF01; rom[2] = 16'hFFFF;
    b_fr = nfr[0];
    begin
      int t0;
      t0 = cyc;
      run(0, -1, lat);
      chk_rng("delay_first_fall", start_cyc[0] - t0, 122, 140);
    end
    chk("delay_frames", nfr[0] - b_fr, 1);
    chk_frame(0, b_fr, 8'hFF, 8'h01);

    // Four-entry table, then replay after done
    for (int i = 0; i < 4; i++) rom[i] = tbl[i].word;
    rom[4] = 16'hFFFF;
    for (int pass = 0; pass < 2; pass++) begin
      b_start = n_start[0]; b_stop = n_stop[0]; b_fr = nfr[0]; b_viol = n_viol[0]; b_bad = n_bad[0];
      run(0, -1, lat);
      chk($sformatf("tbl_starts_p%0d", pass), n_start[0] - b_start, 4);
      chk($sformatf("tbl_stops_p%0d", pass), n_stop[0] - b_stop, 4);
      chk($sformatf("tbl_frames_p%0d", pass), nfr[0] - b_fr, 4);
      chk($sformatf("tbl_viol_p%0d", pass), n_viol[0] - b_viol, 0);
      chk($sformatf("tbl_bad_p%0d", pass), n_bad[0] - b_bad, 0);
      chk($sformatf("tbl_addr_p%0d", pass), {24'd0, rom_addr}, 32'd4);
      for (int i = 0; i < 4; i++) chk_frame(0, b_fr + i, tbl[i].r, tbl[i].v);
    end

    // Missing sentinel on a 2-bit address table
    b_fr = nfr[1]; b_start = n_start[1];
    run(1, -1, lat);
    chk("nosent_frames", nfr[1] - b_fr, 4);
    chk("nosent_starts", n_start[1] - b_start, 4);
    chk("nosent_addr", {30'd0, rom_addr2}, 32'd3);
    chk("nosent_cam", cam_enable2, 1);
    for (int i = 0; i < 4; i++) chk_frame(1, b_fr + i, tbl2[i].r, tbl2[i].v);

    // Reset in the middle of the second write
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (1500) @(negedge clk);
    chk("mid_addr_before", {24'd0, rom_addr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sio_c", sio_c, 1);
    chk("mid_rst_oe", sio_d_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", {24'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov2640_sccb_config.md
Name: ov2640_sccb_config

Overview:
Power-up configuration sequencer for the OV2640 camera. It walks a register table held in an external synchronous ROM and writes each {register, value} pair to the sensor over SCCB (3-phase write, open-drain). When the table ends, it asserts cam_enable, which gates the capture core's enable input. It runs in the system clock domain, upstream of the PCLK capture path.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency.
SCCB_FREQ_HZ, 100000, SIO_C frequency. QTR = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) cycles per quarter bit.
DEV_ADDR, 8'h60, SCCB write ID byte.
ADDR_W, 8, ROM address width. The table holds at most 2^ADDR_W entries.
PWR_WAIT, 1000000, cycles to wait after start before the first transaction.
DELAY_CYCLES, 500000, cycles consumed by one delay-entry.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins the configuration run
busy  out  1  high while a run is in progress
done  out  1  high after the table has been completed; held until the next start or rst
cam_enable  out  1  enable to the capture core; equals done
rom_addr  out  ADDR_W  table index
rom_data  in  16  {reg[15:8], val[7:0]}; valid 1 cycle after rom_addr changes
sio_c  out  1  SCCB clock, push-pull
sio_d_o  out  1  SCCB data drive value; always 0
sio_d_oe  out  1  1 = pull SIO_D low, 0 = release (pull-up gives high)

Behaviour:
- Reset values: sio_c=1, sio_d_oe=0, sio_d_o=0, busy=0, done=0, cam_enable=0, rom_addr=0. All state returns to IDLE and all counters clear. rst mid-transaction releases the bus on the next cycle with no stop condition.
- States: IDLE, PWR_WAIT, FETCH, DECODE, START, SHIFT, STOP, GAP, DELAY, DONE.
- IDLE/DONE: on start, go to PWR_WAIT; set busy=1, done=0, rom_addr=0. start while busy is ignored.
- PWR_WAIT: count PWR_WAIT cycles, then go to FETCH.
- FETCH: wait 1 cycle for ROM latency, then go to DECODE.
- DECODE:
  - rom_data==16'hFFFF: end of table, go to DONE.
  - rom_data==16'hFFF0: go to DELAY.
  - Otherwise: latch a 27-bit shift frame {DEV_ADDR,X, reg,X, val,X}, where X is the 9th don't-care bit, then go to START.
- START: 2 quarters.
  - Q0: SIO_C high, SIO_D released.
  - Q1: SIO_D driven low, SIO_C still high.
  - Then SIO_C goes low and the FSM enters SHIFT.
- SHIFT: 27 bits, MSB first, 4 quarters per bit.
  - Q0: SIO_C low; set SIO_D (oe = ~bit). X bits always released.
  - Q1: SIO_C low.
  - Q2, Q3: SIO_C high.
  - SIO_D changes only while SIO_C is low.
  - Bit counter runs 26 down to 0, then go to STOP. The acknowledge/X bit is not sampled; no error path exists.
- STOP: 3 quarters.
  - Q0: SIO_C low, SIO_D low.
  - Q1: SIO_C high, SIO_D low.
  - Q2: release SIO_D.
  - Then go to GAP.
- GAP: 4 quarters idle with the bus high. Then:
  - rom_addr == 2^ADDR_W-1: go to DONE (table exhausted without a sentinel).
  - Otherwise: rom_addr+1, go to FETCH.
- DELAY: count DELAY_CYCLES, then advance rom_addr exactly as at the end of GAP.
- DONE: busy=0, done=1, cam_enable=1. The bus stays idle (sio_c=1, oe=0).
- Counters: the quarter counter is wide enough for QTR-1 and resets at each phase boundary. The PWR/DELAY counter is wide enough for the larger of PWR_WAIT and DELAY_CYCLES. No wrap-around occurs inside a phase.
- Per-write duration: (2+108+3+4)*QTR + 2 cycles (FETCH + DECODE) = 117*QTR + 2 clk cycles.

Test Plan:
- Reset values: CLK 4 MHz, SCCB 100 kHz (QTR=10), PWR_WAIT=20. Assert rst mid-table -> next cycle sio_c=1, sio_d_oe=0, busy=0, rom_addr=0.
- Single write: ROM {0:16'h12_80, 1:16'hFFFF}. Pulse start -> SCCB monitor decodes ID 0x60, reg 0x12, val 0x80. done rises 20+2+1172+2 ±2 cycles after start; cam_enable=1.
- Delay entry: ROM {16'hFFF0, 16'hFF01, 16'hFFFF} with DELAY_CYCLES=100 -> the first SIO_D fall occurs ≥100 cycles after the delay fetch; the decoded write is reg 0xFF, val 0x01.
- Protocol checker: a full 4-entry table -> SIO_D never toggles while SIO_C is high, except at start/stop. Exactly 4 start and 4 stop conditions; X bits released.
- Missing sentinel: ADDR_W=2, four ordinary entries -> four writes, then done; rom_addr ends at 3.
- start during busy is ignored. A second start after done -> done/cam_enable drop the next cycle and the table is replayed identically.
